// File: rtl/etx_pkg.sv
// Shared definitions for the eLink transmit byte serializer.
package etx_pkg;

  // Default emesh packet width in bits.
  localparam int PW_DEFAULT = 104;

  // Bit of the packet that flags a write (1) versus a read request (0).
  localparam int WRITE_BIT = 0;

  // Serializer states: idle between packets, or streaming bytes.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } etx_state_t;

endpackage

// File: rtl/etx_byte_serializer.sv
// Transmit-side eLink byte serializer: buffers one emesh packet and streams it
// MSB-first onto the TX byte lane, honouring remote wr/rd wait at packet starts.
module etx_byte_serializer
  import etx_pkg::*;
#(
  parameter int PW = PW_DEFAULT,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          in_access,
  input  logic [PW-1:0] in_packet,
  output logic          in_wait,
  input  logic          txi_wr_wait,
  input  logic          txi_rd_wait,
  output logic          txo_frame,
  output logic [7:0]    txo_data,
  output logic [CW-1:0] tx_count
);

  localparam int NB = PW / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NB - 1);
  localparam logic [IW-1:0] PENULT_IDX = IW'(NB - 2);

  etx_state_t    state, state_nx;
  logic [PW-1:0] hold;
  logic          hold_valid;
  logic [PW-1:0] shift;
  logic [IW-1:0] idx;

  logic accept;
  logic blocked;
  logic go;
  logic start;
  logic advance;

  // A packet is only taken while the holding register is empty.
  assign accept  = in_access && !hold_valid;
  assign in_wait = hold_valid;

  // The pending packet's own type decides which remote wait applies.
  assign blocked = hold[WRITE_BIT] ? txi_wr_wait : txi_rd_wait;
  assign go      = hold_valid && !blocked;

  // State register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nx;
  end

  // Next state: start points are IDLE and the last byte of a packet; waits are
  // only consulted there so a packet in flight is never cut short.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          start    = 1'b1;
          state_nx = SEND;
        end
      end
      SEND: begin
        if (idx == LAST_IDX) begin
          if (go) start    = 1'b1;
          else    state_nx = IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control and registered outputs: hold occupancy, byte index, frame, data lane
  // and the sent-packet counter (bumped on the edge that presents the last byte).
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      hold_valid <= 1'b0;
      idx        <= '0;
      txo_frame  <= 1'b0;
      txo_data   <= '0;
      tx_count   <= '0;
    end else begin
      if (accept)     hold_valid <= 1'b1;
      else if (start) hold_valid <= 1'b0;

      if (start) begin
        idx       <= '0;
        txo_frame <= 1'b1;
        txo_data  <= hold[PW-1 -: 8];
      end else if (advance) begin
        idx       <= idx + IW'(1);
        txo_frame <= 1'b1;
        txo_data  <= shift[PW-1 -: 8];
        if (idx == PENULT_IDX) tx_count <= tx_count + CW'(1);
      end else begin
        txo_frame <= 1'b0;
        txo_data  <= '0;
      end
    end
  end

  // Packet data: hold captures on accept; shift keeps the not-yet-sent bytes
  // left-aligned so the next byte is always the top byte.
  always_ff @(posedge clk) begin
    if (accept) hold <= in_packet;
    if (start)        shift <= hold << 8;
    else if (advance) shift <= shift << 8;
  end

endmodule

// File: tb/tb_etx_byte_serializer.sv
// Directed bench for etx_byte_serializer: vector table of single packets plus
// hand-written back-to-back, mid-packet wait, reset and counter-wrap sequences.
module tb_etx_byte_serializer;

  localparam int PW = 104;
  localparam int NB = PW / 8;

  logic          clk = 1'b0;
  logic          resetb;
  logic          in_access;
  logic [PW-1:0] in_packet;
  logic          in_wait;
  logic          txi_wr_wait;
  logic          txi_rd_wait;
  logic          txo_frame;
  logic [7:0]    txo_data;
  logic [15:0]   tx_count;

  logic          in_wait4;
  logic          txo_frame4;
  logic [7:0]    txo_data4;
  logic [3:0]    tx_count4;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_count = 0;

  etx_byte_serializer #(.PW(PW), .CW(16)) dut (
    .clk(clk), .resetb(resetb), .in_access(in_access), .in_packet(in_packet),
    .in_wait(in_wait), .txi_wr_wait(txi_wr_wait), .txi_rd_wait(txi_rd_wait),
    .txo_frame(txo_frame), .txo_data(txo_data), .tx_count(tx_count)
  );

  etx_byte_serializer #(.PW(PW), .CW(4)) dut4 (
    .clk(clk), .resetb(resetb), .in_access(in_access), .in_packet(in_packet),
    .in_wait(in_wait4), .txi_wr_wait(txi_wr_wait), .txi_rd_wait(txi_rd_wait),
    .txo_frame(txo_frame4), .txo_data(txo_data4), .tx_count(tx_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pkt;
    logic          wr_w;
    logic          rd_w;
    logic          held;
    string         name;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mkpkt(input int i);
    logic [PW-1:0] p;
    for (int b = 0; b < NB; b++) p[PW-1-8*b -: 8] = 8'(i * 13 + b + 1);
    p[0] = 1'b1;
    return p;
  endfunction

  // Present one packet while the serializer is free and let it be accepted.
  task automatic offer(input logic [PW-1:0] p, input string nm);
    check({nm, " in_wait before"}, 32'(in_wait), 32'd0);
    in_access = 1'b1;
    in_packet = p;
    tick();
    in_access = 1'b0;
    in_packet = '0;
    check({nm, " in_wait after accept"}, 32'(in_wait), 32'd1);
  endtask

  // Expect the packet to begin on the next edge and run NB bytes, MSB first.
  task automatic expect_packet(input logic [PW-1:0] p, input string nm);
    for (int b = 0; b < NB; b++) begin
      tick();
      check({nm, " frame"}, 32'(txo_frame), 32'd1);
      check({nm, " byte"}, 32'(txo_data), 32'(p[PW-1-8*b -: 8]));
      if (b == 0) check({nm, " in_wait after transfer"}, 32'(in_wait), 32'd0);
    end
    exp_count++;
    check({nm, " tx_count"}, 32'(tx_count), 32'(exp_count));
    tick();
    check({nm, " frame end"}, 32'(txo_frame), 32'd0);
    check({nm, " data end"}, 32'(txo_data), 32'd0);
  endtask

  // Producer presents n packets continuously; collect every framed byte.
  task automatic stream(input int n, input string nm);
    logic [PW-1:0] pk[$];
    logic [7:0]    expb[$];
    logic [7:0]    got[$];
    int            sent = 0;
    int            run = 0;
    int            best = 0;
    logic          acc;
    for (int i = 0; i < n; i++) begin
      pk.push_back(mkpkt(i));
      for (int b = 0; b < NB; b++) expb.push_back(pk[i][PW-1-8*b -: 8]);
    end
    in_access = 1'b1;
    in_packet = pk[0];
    for (int c = 0; c < n * NB + 20; c++) begin
      acc = in_access && !in_wait;
      tick();
      if (acc) sent++;
      in_access = (sent < n);
      in_packet = (sent < n) ? pk[sent] : '0;
      if (txo_frame) begin
        got.push_back(txo_data);
        run++;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    in_access = 1'b0;
    exp_count += n;
    check({nm, " frame run"}, 32'(best), 32'(n * NB));
    check({nm, " byte count"}, 32'(got.size()), 32'(expb.size()));
    for (int i = 0; i < got.size() && i < expb.size(); i++)
      check({nm, " byte"}, 32'(got[i]), 32'(expb[i]));
    check({nm, " tx_count"}, 32'(tx_count), 32'(exp_count));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    logic [PW-1:0] w1, w2, p;

    vecs[0] = '{104'h0102030405060708090A0B0C0D, 1'b0, 1'b0, 1'b0, "write free"};
    vecs[1] = '{104'hA0A1A2A3A4A5A6A7A8A9AAABAC, 1'b1, 1'b0, 1'b0, "read wrwait"};
    vecs[2] = '{104'hB0B1B2B3B4B5B6B7B8B9BABBBC, 1'b0, 1'b1, 1'b1, "read rdwait"};
    vecs[3] = '{104'hC0C1C2C3C4C5C6C7C8C9CACBCD, 1'b1, 1'b0, 1'b1, "write wrwait"};
    vecs[4] = '{104'hD0D1D2D3D4D5D6D7D8D9DADBDF, 1'b0, 1'b1, 1'b0, "write rdwait"};
    vecs[5] = '{104'hFFFFFFFFFFFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 1'b0, "all ones"};

    resetb      = 1'b0;
    in_access   = 1'b0;
    in_packet   = '0;
    txi_wr_wait = 1'b0;
    txi_rd_wait = 1'b0;
    tick();
    tick();
    check("reset frame", 32'(txo_frame), 32'd0);
    check("reset data", 32'(txo_data), 32'd0);
    check("reset in_wait", 32'(in_wait), 32'd0);
    check("reset tx_count", 32'(tx_count), 32'd0);
    #3 resetb = 1'b1;
    tick();

    // Single-packet vectors, some held off by the remote wait.
    for (int v = 0; v < 6; v++) begin
      txi_wr_wait = vecs[v].wr_w;
      txi_rd_wait = vecs[v].rd_w;
      offer(vecs[v].pkt, vecs[v].name);
      if (vecs[v].held) begin
        for (int c = 0; c < 5; c++) begin
          tick();
          check({vecs[v].name, " held frame"}, 32'(txo_frame), 32'd0);
          check({vecs[v].name, " held in_wait"}, 32'(in_wait), 32'd1);
        end
        txi_wr_wait = 1'b0;
        txi_rd_wait = 1'b0;
      end
      expect_packet(vecs[v].pkt, vecs[v].name);
      txi_wr_wait = 1'b0;
      txi_rd_wait = 1'b0;
      tick();
    end
    check("count4 after table", 32'(tx_count4), 32'd6);

    // Three back-to-back packets with no frame gap.
    stream(3, "b2b");
    tick();

    // Write wait raised mid-packet: current packet completes, next one waits.
    w1 = 104'h1112131415161718191A1B1C1D;
    w2 = 104'h2122232425262728292A2B2C2D;
    offer(w1, "midwait w1");
    tick();
    check("midwait w1 frame", 32'(txo_frame), 32'd1);
    check("midwait w1 byte", 32'(txo_data), 32'h11);
    in_access = 1'b1;
    in_packet = w2;
    for (int b = 1; b < NB; b++) begin
      tick();
      if (b == 1) begin
        in_access = 1'b0;
        in_packet = '0;
        check("midwait w2 accepted", 32'(in_wait), 32'd1);
      end
      check("midwait w1 frame", 32'(txo_frame), 32'd1);
      check("midwait w1 byte", 32'(txo_data), 32'(w1[PW-1-8*b -: 8]));
      if (b == 5) txi_wr_wait = 1'b1;
    end
    exp_count++;
    check("midwait w1 tx_count", 32'(tx_count), 32'(exp_count));
    for (int c = 0; c < 4; c++) begin
      tick();
      check("midwait w2 held frame", 32'(txo_frame), 32'd0);
      check("midwait w2 held in_wait", 32'(in_wait), 32'd1);
    end
    txi_wr_wait = 1'b0;
    expect_packet(w2, "midwait w2");
    tick();

    // Asynchronous reset while byte 7 is on the lane.
    p = 104'h3132333435363738393A3B3C3D;
    offer(p, "rst pkt");
    for (int b = 0; b < 8; b++) begin
      tick();
      check("rst pkt byte", 32'(txo_data), 32'(p[PW-1-8*b -: 8]));
    end
    #1 resetb = 1'b0;
    #1;
    check("rst async frame", 32'(txo_frame), 32'd0);
    check("rst async data", 32'(txo_data), 32'd0);
    check("rst async in_wait", 32'(in_wait), 32'd0);
    check("rst async tx_count", 32'(tx_count), 32'd0);
    check("rst async count4", 32'(tx_count4), 32'd0);
    exp_count = 0;
    tick();
    #2 resetb = 1'b1;
    tick();
    check("rst no tail frame", 32'(txo_frame), 32'd0);
    p = 104'h4142434445464748494A4B4C4D;
    offer(p, "post rst");
    expect_packet(p, "post rst");

    // Counter wrap on the 4-bit instance after 17 packets.
    #2 resetb = 1'b0;
    exp_count = 0;
    #2 resetb = 1'b1;
    tick();
    stream(17, "wrap");
    check("wrap count4", 32'(tx_count4), 32'd1);
    check("wrap count16", 32'(tx_count), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
